// File: rtl/kgp_risc_pkg.sv
// Shared definitions for the KGP RISC execute/writeback slice.
// Holds the opcodes, the FSM states and the default widths.
package kgp_risc_pkg;

  localparam int unsigned KGP_DATA_W  = 32;
  localparam int unsigned KGP_ADDR_W  = 5;
  localparam int unsigned KGP_SHAMT_W = 5;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_COMP = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_SLL  = 3'd4;
  localparam logic [2:0] OP_SRL  = 3'd5;
  localparam logic [2:0] OP_SRA  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_WB    = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/exec_writeback_unit_if.sv
// Request/register-file-write bundle between the operand source and the execute stage.
interface exec_writeback_unit_if
  import kgp_risc_pkg::*;
#(
  parameter int unsigned DATA_W = KGP_DATA_W,
  parameter int unsigned ADDR_W = KGP_ADDR_W
);
  logic              start;
  logic [2:0]        op;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] dest;
  logic              busy;
  logic [ADDR_W-1:0] WriteAddr;
  logic [DATA_W-1:0] WriteData;
  logic              reg_write;
  logic              done;
  logic              carry;
  logic              zero;
  logic              sign;

  modport master (
    output start, op, ReadData1, ReadData2, dest,
    input  busy, WriteAddr, WriteData, reg_write, done, carry, zero, sign
  );

  modport slave (
    input  start, op, ReadData1, ReadData2, dest,
    output busy, WriteAddr, WriteData, reg_write, done, carry, zero, sign
  );
endinterface

// File: rtl/exec_writeback_unit_shifter.sv
// One-bit-per-cycle shifter: load captures operand, amount and direction;
// each step shifts by one and counts down.
module seq_shifter
  import kgp_risc_pkg::*;
#(
  parameter int unsigned DATA_W  = KGP_DATA_W,
  parameter int unsigned SHAMT_W = KGP_SHAMT_W
) (
  input  logic               clka,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [2:0]         op,
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] amount,
  output logic [DATA_W-1:0]  shifted,
  output logic               done
);
  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  logic [DATA_W-1:0]  acc;
  logic [SHAMT_W-1:0] cnt;
  logic               left;
  logic               arith;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      cnt   <= '0;
      left  <= 1'b0;
      arith <= 1'b0;
    end else if (load) begin
      acc   <= a;
      cnt   <= amount;
      left  <= (op == OP_SLL);
      arith <= (op == OP_SRA);
    end else if (step) begin
      acc <= shifted;
      cnt <= cnt - CNT_ONE;
    end
  end

  // shifted is the acc value after the current step, so the final step's
  // result can be captured in the same edge that retires it.
  assign shifted = left ? {acc[DATA_W-2:0], 1'b0}
                        : {arith & acc[DATA_W-1], acc[DATA_W-1:1]};
  assign done    = step && (cnt == CNT_ONE);

endmodule

// File: rtl/exec_writeback_unit.sv
// Multi-cycle execute stage: single-cycle ALU ops, iterative shifts,
// and the registered RegisterFile write port plus status flags.
module exec_writeback_unit
  import kgp_risc_pkg::*;
#(
  parameter int unsigned DATA_W  = KGP_DATA_W,
  parameter int unsigned ADDR_W  = KGP_ADDR_W,
  parameter int unsigned SHAMT_W = KGP_SHAMT_W
) (
  input  logic                  clka,
  input  logic                  rst_n,
  exec_writeback_unit_if.slave  bus
);
  localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

  state_t             state;
  state_t             state_next;
  logic [DATA_W-1:0]  alu_result;
  logic               alu_carry;
  logic [DATA_W:0]    sum;
  logic [SHAMT_W-1:0] amount;
  logic               shift_req;
  logic               accept;
  logic               sh_load;
  logic               sh_step;
  logic               sh_done;
  logic [DATA_W-1:0]  sh_shifted;
  logic               load_wb;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_carry;
  logic [ADDR_W-1:0]  wb_dest;
  logic [ADDR_W-1:0]  dest_q;

  assign amount    = bus.ReadData2[SHAMT_W-1:0];
  assign shift_req = is_shift(bus.op) && (amount != '0);
  assign accept    = (state == S_IDLE) && bus.start;
  assign sh_load   = accept && shift_req;
  assign sh_step   = (state == S_SHIFT);
  assign load_wb   = (accept && !shift_req) || sh_done;
  assign bus.busy  = (state != S_IDLE);

  seq_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clka    (clka),
    .rst_n   (rst_n),
    .load    (sh_load),
    .step    (sh_step),
    .op      (bus.op),
    .a       (bus.ReadData1),
    .amount  (amount),
    .shifted (sh_shifted),
    .done    (sh_done)
  );

  assign sum = {1'b0, bus.ReadData1} + {1'b0, bus.ReadData2};

  always_comb begin
    alu_result = bus.ReadData1;
    alu_carry  = 1'b0;
    case (bus.op)
      OP_ADD:  begin
        alu_result = sum[DATA_W-1:0];
        alu_carry  = sum[DATA_W];
      end
      OP_COMP: begin
        alu_result = ~bus.ReadData2 + DATA_ONE;
        alu_carry  = (bus.ReadData2 == '0);
      end
      OP_AND:  alu_result = bus.ReadData1 & bus.ReadData2;
      OP_XOR:  alu_result = bus.ReadData1 ^ bus.ReadData2;
      default: alu_result = bus.ReadData1;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (bus.start) state_next = shift_req ? S_SHIFT : S_WB;
      S_SHIFT: if (sh_done) state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Write-port and flag registers load on the edge entering WB, so they
  // present the result during the WB cycle and hold it afterwards.
  assign wb_data  = sh_step ? sh_shifted : alu_result;
  assign wb_carry = sh_step ? 1'b0 : alu_carry;
  assign wb_dest  = sh_step ? dest_q : bus.dest;

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      dest_q        <= '0;
      bus.WriteAddr <= '0;
      bus.WriteData <= '0;
      bus.reg_write <= 1'b0;
      bus.done      <= 1'b0;
      bus.carry     <= 1'b0;
      bus.zero      <= 1'b0;
      bus.sign      <= 1'b0;
    end else begin
      if (accept) dest_q <= bus.dest;
      bus.done      <= load_wb;
      bus.reg_write <= load_wb && (wb_dest != '0);
      if (load_wb) begin
        bus.WriteAddr <= wb_dest;
        bus.WriteData <= wb_data;
        bus.carry     <= wb_carry;
        bus.zero      <= (wb_data == '0);
        bus.sign      <= wb_data[DATA_W-1];
      end
    end
  end

endmodule

// File: tb/tb_exec_writeback_unit.sv
// Self-checking bench: directed vector table, randomized ops against a
// behavioural model, and hand-written hazard/reset sequences.
module tb_exec_writeback_unit;
  import kgp_risc_pkg::*;

  logic clka  = 1'b0;
  logic rst_n = 1'b0;
  always #100 clka = ~clka;

  exec_writeback_unit_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  exec_writeback_unit #(.DATA_W(32), .ADDR_W(5), .SHAMT_W(5)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic [31:0] exp_data;
    logic        exp_c;
    logic        exp_z;
    logic        exp_s;
    int unsigned exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain arithmetic on whole words, no cycle-level modelling.
  function automatic void ref_model(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] r,
                                    output logic c, output int unsigned lat);
    int unsigned n;
    logic [32:0] wide;
    n   = b % 32;
    c   = 1'b0;
    lat = 1;
    r   = a;
    case (op)
      OP_ADD:  begin wide = {1'b0, a} + {1'b0, b}; r = wide[31:0]; c = wide[32]; end
      OP_COMP: begin r = 32'd0 - b; c = (b == 32'd0); end
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      OP_SLL:  r = a << n;
      OP_SRL:  r = a >> n;
      OP_SRA:  r = $unsigned($signed(a) >>> n);
      default: r = a;
    endcase
    if (is_shift(op) && n != 0) lat = n + 1;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, output logic [31:0] data, output logic [4:0] addr,
                        output logic c, output logic z, output logic s, output logic rw,
                        output int unsigned lat, output bit early_rw, output bit timeout);
    data = '0; addr = '0; c = 0; z = 0; s = 0; rw = 0;
    lat = 0; early_rw = 0; timeout = 1;
    @(negedge clka);
    bus.op = op; bus.ReadData1 = a; bus.ReadData2 = b; bus.dest = d; bus.start = 1'b1;
    @(posedge clka);
    #1;
    bus.start     = 1'b0;
    bus.op        = 3'($urandom());
    bus.ReadData1 = $urandom();
    bus.ReadData2 = $urandom();
    bus.dest      = 5'($urandom());
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clka);
      if (bus.done) begin
        lat = cyc; timeout = 0;
        data = bus.WriteData; addr = bus.WriteAddr;
        c = bus.carry; z = bus.zero; s = bus.sign; rw = bus.reg_write;
        break;
      end
      if (bus.reg_write) early_rw = 1;
    end
  endtask

  task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] exp_data,
                          input logic exp_c, input logic exp_z, input logic exp_s,
                          input int unsigned exp_lat);
    logic [31:0] data; logic [4:0] addr; logic c, z, s, rw;
    int unsigned lat; bit early_rw, timeout;
    run_op(op, a, b, d, data, addr, c, z, s, rw, lat, early_rw, timeout);
    chk({tag, " timeout"}, 64'(timeout), 64'd0);
    chk({tag, " data"}, 64'(data), 64'(exp_data));
    chk({tag, " addr"}, 64'(addr), 64'(d));
    chk({tag, " carry"}, 64'(c), 64'(exp_c));
    chk({tag, " zero"}, 64'(z), 64'(exp_z));
    chk({tag, " sign"}, 64'(s), 64'(exp_s));
    chk({tag, " reg_write"}, 64'(rw), 64'(d != 5'd0));
    chk({tag, " early_write"}, 64'(early_rw), 64'd0);
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    @(negedge clka);
    chk({tag, " done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, " rw_drop"}, 64'(bus.reg_write), 64'd0);
    chk({tag, " busy_drop"}, 64'(bus.busy), 64'd0);
    chk({tag, " data_hold"}, 64'(bus.WriteData), 64'(exp_data));
    chk({tag, " carry_hold"}, 64'(bus.carry), 64'(exp_c));
  endtask

  initial begin
    logic [31:0] r, a, b;
    logic [2:0]  op;
    logic [4:0]  d;
    logic        c;
    int unsigned lat;
    bit          early_rw;
    bit          seen_rw;

    vecs[0] = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 5'd1, 32'h00000000, 1, 1, 0, 1};
    vecs[1] = '{OP_SRA,  32'h80000000, 32'h00000004, 5'd3, 32'hF8000000, 0, 0, 1, 5};
    vecs[2] = '{OP_SLL,  32'h00000001, 32'h00000000, 5'd4, 32'h00000001, 0, 0, 0, 1};
    vecs[3] = '{OP_SLL,  32'h00000001, 32'h0000001F, 5'd5, 32'h80000000, 0, 0, 1, 32};
    vecs[4] = '{OP_XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'hFF00FF00, 0, 0, 1, 1};
    vecs[5] = '{OP_COMP, 32'h12345678, 32'h00000000, 5'd6, 32'h00000000, 1, 1, 0, 1};
    vecs[6] = '{OP_AND,  32'hAAAAAAAA, 32'h0F0F0F0F, 5'd7, 32'h0A0A0A0A, 0, 0, 0, 1};
    vecs[7] = '{OP_SRL,  32'h80000001, 32'h00000021, 5'd8, 32'h40000000, 0, 0, 0, 2};
    vecs[8] = '{OP_COMP, 32'h00000000, 32'h00000005, 5'd9, 32'hFFFFFFFB, 0, 0, 1, 1};
    vecs[9] = '{OP_PASS, 32'h7FFFFFFF, 32'h00000000, 5'd31, 32'h7FFFFFFF, 0, 0, 0, 1};

    bus.start = 0; bus.op = '0; bus.ReadData1 = '0; bus.ReadData2 = '0; bus.dest = '0;

    // Reset held with start toggling.
    #50 bus.start = 1; bus.op = OP_ADD; bus.ReadData1 = 32'h5; bus.ReadData2 = 32'h7; bus.dest = 5'd2;
    #100;
    chk("rst busy", 64'(bus.busy), 64'd0);
    chk("rst reg_write", 64'(bus.reg_write), 64'd0);
    chk("rst done", 64'(bus.done), 64'd0);
    chk("rst addr", 64'(bus.WriteAddr), 64'd0);
    chk("rst data", 64'(bus.WriteData), 64'd0);
    chk("rst flags", 64'({bus.carry, bus.zero, bus.sign}), 64'd0);
    bus.start = 0;
    #40 rst_n = 1;

    foreach (vecs[i])
      check_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dest,
               vecs[i].exp_data, vecs[i].exp_c, vecs[i].exp_z, vecs[i].exp_s, vecs[i].exp_lat);

    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = a;
        default: ;
      endcase
      d = 5'($urandom_range(0, 31));
      ref_model(op, a, b, r, c, lat);
      check_op($sformatf("rnd%0d", k), op, a, b, d, r, c, r == 32'd0, r[31], lat);
    end

    // start held high across an SRL: ignored while busy and during WB.
    @(negedge clka);
    bus.op = OP_SRL; bus.ReadData1 = 32'hAAAAAAAA; bus.ReadData2 = 32'd8; bus.dest = 5'd9;
    bus.start = 1;
    lat = 0; early_rw = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clka);
      if (cyc == 1) begin
        bus.op = OP_ADD; bus.ReadData1 = 32'h0; bus.ReadData2 = 32'h5; bus.dest = 5'd4;
      end
      if (bus.done) begin lat = cyc; break; end
      if (bus.reg_write) early_rw = 1;
    end
    chk("hold srl data", 64'(bus.WriteData), 64'h00AAAAAA);
    chk("hold srl addr", 64'(bus.WriteAddr), 64'd9);
    chk("hold srl latency", 64'(lat), 64'd9);
    chk("hold srl early_write", 64'(early_rw), 64'd0);
    bus.op = OP_PASS; bus.ReadData1 = 32'h00001234; bus.dest = 5'd2;
    @(negedge clka);
    chk("hold wb ignored busy", 64'(bus.busy), 64'd0);
    chk("hold wb ignored done", 64'(bus.done), 64'd0);
    @(negedge clka);
    chk("hold next done", 64'(bus.done), 64'd1);
    chk("hold next data", 64'(bus.WriteData), 64'h00001234);
    chk("hold next addr", 64'(bus.WriteAddr), 64'd2);
    bus.start = 0;
    @(negedge clka);
    chk("hold idle busy", 64'(bus.busy), 64'd0);

    // Leave non-zero state behind, then abort a shift with reset.
    check_op("pre_rst", vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].dest,
             vecs[0].exp_data, vecs[0].exp_c, vecs[0].exp_z, vecs[0].exp_s, vecs[0].exp_lat);
    @(negedge clka);
    bus.op = OP_SLL; bus.ReadData1 = 32'h1; bus.ReadData2 = 32'd20; bus.dest = 5'd10;
    bus.start = 1;
    @(posedge clka);
    #1 bus.start = 0;
    repeat (3) @(negedge clka);
    chk("abort busy before", 64'(bus.busy), 64'd1);
    rst_n = 0;
    #1;
    chk("abort busy async", 64'(bus.busy), 64'd0);
    chk("abort addr", 64'(bus.WriteAddr), 64'd0);
    chk("abort flags", 64'({bus.carry, bus.zero, bus.sign}), 64'd0);
    seen_rw = 0;
    repeat (2) begin @(negedge clka); seen_rw |= bus.reg_write | bus.done; end
    rst_n = 1;
    repeat (25) begin @(negedge clka); seen_rw |= bus.reg_write | bus.done | bus.busy; end
    chk("abort no write", 64'(seen_rw), 64'd0);
    chk("abort data", 64'(bus.WriteData), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
